// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter that shares one FIFO between N producers.
// Tracks committed occupancy, including the in-flight push, so it never pushes into a full FIFO.
module fifo_push_arbiter #(
    parameter int N     = 4,
    parameter int BITS  = 16,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*BITS-1:0] din,
    output logic [N-1:0]      gnt,
    output logic [BITS-1:0]   fifo_din,
    output logic              fifo_push,
    input  logic              fifo_pop,
    input  logic              fifo_pndng,
    input  logic              fifo_full,
    output logic [IW-1:0]     src_id,
    output logic [CW-1:0]     occ,
    output logic              err
);

    logic [IW-1:0]   rr_ptr_r;
    logic [BITS-1:0] fifo_din_r;
    logic            fifo_push_r;
    logic [IW-1:0]   src_id_r;
    logic [CW-1:0]   occ_r;
    logic            err_r;

    logic            can_grant_s;
    logic            found_s;
    logic [IW-1:0]   gidx_s;
    logic [IW-1:0]   cand_s;
    logic [N-1:0]    gnt_s;
    logic [BITS-1:0] din_sel_s;
    logic            pop_v_s;
    logic            pop_eff_s;
    logic [CW-1:0]   occ_nxt_s;

    assign can_grant_s = (occ_r < CW'(DEPTH));

    // Round-robin search starting just after the last granted requester
    always_comb begin
        found_s   = 1'b0;
        gidx_s    = '0;
        cand_s    = '0;
        gnt_s     = '0;
        din_sel_s = '0;
        if (rst && can_grant_s && (req != '0)) begin
            for (int k = 1; k <= N; k++) begin
                cand_s = IW'((int'(rr_ptr_r) + k) % N);
                if (!found_s && req[cand_s]) begin
                    found_s = 1'b1;
                    gidx_s  = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
        if (found_s) begin
            gnt_s[gidx_s] = 1'b1;
            din_sel_s     = din[gidx_s*BITS +: BITS];
        end else begin
            gnt_s = '0;
        end
    end

    // Occupancy bookkeeping; a pop at zero occupancy is ignored
    always_comb begin
        pop_v_s   = fifo_pop & fifo_pndng;
        pop_eff_s = pop_v_s & (occ_r != '0);
        occ_nxt_s = occ_r;
        case ({found_s, pop_eff_s})
            2'b10:   occ_nxt_s = occ_r + CW'(1);
            2'b01:   occ_nxt_s = occ_r - CW'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Registered push path, arbitration pointer, occupancy and overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_r    <= IW'(N - 1);
            fifo_din_r  <= '0;
            fifo_push_r <= 1'b0;
            src_id_r    <= '0;
            occ_r       <= '0;
            err_r       <= 1'b0;
        end else begin
            fifo_push_r <= found_s;
            if (found_s) begin
                fifo_din_r <= din_sel_s;
                src_id_r   <= gidx_s;
                rr_ptr_r   <= gidx_s;
            end
            occ_r <= occ_nxt_s;
            // Pushing into a full FIFO means the FIFO and occ disagree
            if (fifo_push_r && fifo_full) begin
                err_r <= 1'b1;
            end
        end
    end

    assign gnt       = gnt_s;
    assign fifo_din  = fifo_din_r;
    assign fifo_push = fifo_push_r;
    assign src_id    = src_id_r;
    assign occ       = occ_r;
    assign err       = err_r;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with a small behavioural FIFO attached.
module tb_fifo_push_arbiter;
    localparam int N = 4, BITS = 16, DEPTH = 16, CW = 5, IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*BITS-1:0] din = '0;
    logic [N-1:0]      gnt;
    logic [BITS-1:0]   fifo_din;
    logic              fifo_push;
    logic              fifo_pop = 1'b0;
    logic              fifo_pndng;
    logic              fifo_full;
    logic [IW-1:0]     src_id;
    logic [CW-1:0]     occ;
    logic              err;
    logic              force_full = 1'b0;

    int errors = 0;
    int checks = 0;

    fifo_push_arbiter #(.N(N), .BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
        .fifo_din(fifo_din), .fifo_push(fifo_push), .fifo_pop(fifo_pop),
        .fifo_pndng(fifo_pndng), .fifo_full(fifo_full), .src_id(src_id),
        .occ(occ), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO standing in for the real one
    logic [BITS-1:0] mem_m [DEPTH];
    logic [3:0]      wr_m = '0;
    logic [3:0]      rd_m = '0;
    logic [4:0]      cnt_m = '0;
    logic            m_push_s;
    logic            m_pop_s;
    assign m_push_s   = fifo_push && (cnt_m != 5'd16);
    assign m_pop_s    = fifo_pop && (cnt_m != 5'd0);
    assign fifo_pndng = (cnt_m != 5'd0);
    assign fifo_full  = (cnt_m == 5'd16) | force_full;

    always @(posedge clk) begin
        if (!rst) begin
            wr_m  <= '0;
            rd_m  <= '0;
            cnt_m <= '0;
        end else begin
            if (m_push_s) begin
                mem_m[wr_m] <= fifo_din;
                wr_m        <= wr_m + 4'd1;
            end
            if (m_pop_s) rd_m <= rd_m + 4'd1;
            cnt_m <= cnt_m + 5'(m_push_s) - 5'(m_pop_s);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; fifo_pop = 1'b0; force_full = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
            tick();
            checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL rst_push: got %b want 0", fifo_push); end
            checks++; if (occ !== 5'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occ); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        end
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt: got %b want 0001", gnt); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        do_reset();
        for (int i = 0; i < N; i++) din[i*BITS +: BITS] = 16'hA000 + 16'(i);
        req = 4'b1111;
        #1;
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL rr_push_pre: got %b want 0", fifo_push); end
        for (int k = 0; k < 6; k++) begin
            exp_g = '0;
            exp_g[k % 4] = 1'b1;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g); end
            tick();
            #1;
            checks++; if (fifo_push !== 1'b1) begin errors++; $display("FAIL rr_push[%0d]: got %b want 1", k, fifo_push); end
            checks++; if (src_id !== IW'(k % 4)) begin errors++; $display("FAIL rr_src[%0d]: got %0d want %0d", k, src_id, k % 4); end
            checks++; if (fifo_din !== 16'hA000 + 16'(k % 4)) begin errors++; $display("FAIL rr_din[%0d]: got %0h want %0h", k, fifo_din, 16'hA000 + 16'(k % 4)); end
            checks++; if (occ !== CW'(k + 1)) begin errors++; $display("FAIL rr_occ[%0d]: got %0d want %0d", k, occ, k + 1); end
        end
    endtask

    task automatic test_fill_and_drain();
        int ngr;
        do_reset();
        ngr = 0;
        din[2*BITS +: BITS] = 16'd0;
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (gnt == 4'b0100) ngr++;
            tick();
            din[2*BITS +: BITS] = 16'(ngr);
        end
        #1;
        checks++; if (ngr != 16) begin errors++; $display("FAIL fill_grants: got %0d want 16", ngr); end
        checks++; if (occ !== 5'd16) begin errors++; $display("FAIL fill_occ: got %0d want 16", occ); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fill_gnt: got %b want 0000", gnt); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", fifo_full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_err: got %b want 0", err); end
        // One pop at full: still no grant this cycle, one grant the next
        fifo_pop = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drain_gnt_at_full: got %b want 0000", gnt); end
        checks++; if (mem_m[rd_m] !== 16'd0) begin errors++; $display("FAIL drain_head0: got %0d want 0", mem_m[rd_m]); end
        tick();
        fifo_pop = 1'b0;
        #1;
        checks++; if (occ !== 5'd15) begin errors++; $display("FAIL drain_occ15: got %0d want 15", occ); end
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL refill_gnt: got %b want 0100", gnt); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if (occ !== 5'd16) begin errors++; $display("FAIL refill_occ: got %0d want 16", occ); end
        for (int j = 0; j < 16; j++) begin
            fifo_pop = 1'b1;
            #1;
            checks++; if (mem_m[rd_m] !== 16'(j + 1)) begin errors++; $display("FAIL drain_order[%0d]: got %0d want %0d", j, mem_m[rd_m], j + 1); end
            tick();
        end
        fifo_pop = 1'b0;
        #1;
        checks++; if (occ !== 5'd0) begin errors++; $display("FAIL drain_occ0: got %0d want 0", occ); end
        checks++; if (fifo_pndng !== 1'b0) begin errors++; $display("FAIL drain_pndng: got %b want 0", fifo_pndng); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        din[0 +: BITS] = 16'h5555;
        req = 4'b0001;
        repeat (5) begin
            #1;
            tick();
        end
        req = 4'b0000;
        #1;
        checks++; if (occ !== 5'd5) begin errors++; $display("FAIL sim_occ_pre: got %0d want 5", occ); end
        req = 4'b0001;
        fifo_pop = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sim_gnt: got %b want 0001", gnt); end
        checks++; if (fifo_pndng !== 1'b1) begin errors++; $display("FAIL sim_pndng: got %b want 1", fifo_pndng); end
        tick();
        req = 4'b0000;
        fifo_pop = 1'b0;
        #1;
        checks++; if (occ !== 5'd5) begin errors++; $display("FAIL sim_occ_hold: got %0d want 5", occ); end
        fifo_pop = 1'b1;
        repeat (8) tick();
        #1;
        checks++; if (occ !== 5'd0) begin errors++; $display("FAIL sim_occ_drain: got %0d want 0", occ); end
        checks++; if (fifo_pndng !== 1'b0) begin errors++; $display("FAIL sim_empty: got %b want 0", fifo_pndng); end
        tick();
        fifo_pop = 1'b0;
        #1;
        checks++; if (occ !== 5'd0) begin errors++; $display("FAIL sim_pop_empty: got %0d want 0", occ); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        req = 4'b1111;
        repeat (7) begin
            #1;
            tick();
        end
        #1;
        checks++; if (occ !== 5'd7) begin errors++; $display("FAIL mid_occ7: got %0d want 7", occ); end
        checks++; if (fifo_push !== 1'b1) begin errors++; $display("FAIL mid_push1: got %b want 1", fifo_push); end
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL mid_gnt_pre: got %b want 1000", gnt); end
        rst = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt_rst: got %b want 0000", gnt); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL mid_push0: got %b want 0", fifo_push); end
        checks++; if (occ !== 5'd0) begin errors++; $display("FAIL mid_occ0: got %0d want 0", occ); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt_post: got %b want 0001", gnt); end
    endtask

    task automatic test_overflow_flag();
        do_reset();
        force_full = 1'b1;
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ovf_gnt: got %b want 0001", gnt); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if (fifo_push !== 1'b1) begin errors++; $display("FAIL ovf_push: got %b want 1", fifo_push); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", err); end
        tick();
        force_full = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_set: got %b want 1", err); end
        tick();
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b want 1", err); end
        do_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_clear: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fill_and_drain();
        test_simultaneous();
        test_midop_reset();
        test_overflow_flag();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
